// File: rtl/vga_out_pkg.sv
// vga_out_pkg: shared 640x480@60 raster constants and types.
// Counter width, default porches, derived totals and sync bounds.
package vga_out_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP
                         + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP
                         + DEF_V_SYNC + DEF_V_BP;

  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic act;
    logic brd;
  } tim_t;

  localparam tim_t TIM_RST = '{
    hs_n: 1'b1,
    vs_n: 1'b1,
    act:  1'b0,
    brd:  1'b0
  };

  function automatic cnt_t cnt_of(int v);
    return cnt_t'(v);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: h/v raster counters with raw sync/active decode.
// Ports: i_clk, i_rst_n, o_h_cnt, o_v_cnt, o_hs_n, o_vs_n, o_active, o_frame_start.
module vga_sync_counter
  import vga_out_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_hs_n,
  output logic             o_vs_n,
  output logic             o_active,
  output logic             o_frame_start
);

  localparam cnt_t L_H_MAX =
    cnt_of(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t L_V_MAX =
    cnt_of(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t L_H_ACT = cnt_of(H_ACTIVE);
  localparam cnt_t L_V_ACT = cnt_of(V_ACTIVE);
  localparam cnt_t L_HS_B  = cnt_of(H_ACTIVE + H_FP);
  localparam cnt_t L_HS_E  = cnt_of(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t L_VS_B  = cnt_of(V_ACTIVE + V_FP);
  localparam cnt_t L_VS_E  = cnt_of(V_ACTIVE + V_FP + V_SYNC);

  cnt_t r_h;
  cnt_t r_v;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == L_H_MAX) begin
      r_h <= '0;
      if (r_v == L_V_MAX) r_v <= '0;
      else                r_v <= r_v + cnt_t'(1);
    end else begin
      r_h <= r_h + cnt_t'(1);
    end
  end

  assign o_h_cnt = r_h;
  assign o_v_cnt = r_v;

  assign o_active = (r_h < L_H_ACT) && (r_v < L_V_ACT);

  assign o_hs_n = !((r_h >= L_HS_B) && (r_h < L_HS_E));
  assign o_vs_n = !((r_v >= L_VS_B) && (r_v < L_VS_E));

  assign o_frame_start = (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/vga_out_timing.sv
// vga_out_timing: VGA raster owner; realigns upstream RGB with sync/blank.
// Ports: vga_clk, arst_n, *_in colour, pix_x/y, pix_active, frame_start,
//   red/green/blue, hsync_n, vsync_n, blank_n. Option: VGA_OUT_BORDER_EN.
module vga_out_timing
  import vga_out_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int SRC_LATENCY = 1
) (
  input  logic       vga_clk,
  input  logic       arst_n,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_active,
  output logic       frame_start,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n
);

  cnt_t w_h;
  cnt_t w_v;
  logic w_hs_n;
  logic w_vs_n;
  logic w_act;
  logic w_brd;
  tim_t w_raw;
  tim_t w_dly;

  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;
  logic       r_hs_n;
  logic       r_vs_n;
  logic       r_blank_n;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_cnt (
    .i_clk         (vga_clk),
    .i_rst_n       (arst_n),
    .o_h_cnt       (w_h),
    .o_v_cnt       (w_v),
    .o_hs_n        (w_hs_n),
    .o_vs_n        (w_vs_n),
    .o_active      (w_act),
    .o_frame_start (frame_start)
  );

  assign pix_x      = w_h;
  assign pix_y      = w_v;
  assign pix_active = w_act;

`ifdef VGA_OUT_BORDER_EN
  localparam cnt_t L_H_LAST = cnt_of(H_ACTIVE - 1);
  localparam cnt_t L_V_LAST = cnt_of(V_ACTIVE - 1);

  assign w_brd = w_act && ((w_h == '0) ||
                           (w_h == L_H_LAST) ||
                           (w_v == '0) ||
                           (w_v == L_V_LAST));
`else
  assign w_brd = 1'b0;
`endif

  assign w_raw = '{
    hs_n: w_hs_n,
    vs_n: w_vs_n,
    act:  w_act,
    brd:  w_brd
  };

  // Delay matches upstream colour latency so the
  // output register sees timing and RGB together.
  if (SRC_LATENCY == 0) begin : g_nodly
    assign w_dly = w_raw;
  end else begin : g_dly
    tim_t r_pipe [SRC_LATENCY];

    always_ff @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) begin
        for (int k = 0; k < SRC_LATENCY; k++)
          r_pipe[k] <= TIM_RST;
      end else begin
        r_pipe[0] <= w_raw;
        for (int k = 1; k < SRC_LATENCY; k++)
          r_pipe[k] <= r_pipe[k-1];
      end
    end

    assign w_dly = r_pipe[SRC_LATENCY-1];
  end

  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
      r_hs_n    <= 1'b1;
      r_vs_n    <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_hs_n    <= w_dly.hs_n;
      r_vs_n    <= w_dly.vs_n;
      r_blank_n <= w_dly.act;
      if (!w_dly.act) begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end else if (w_dly.brd) begin
        r_red   <= 8'hFF;
        r_green <= 8'hFF;
        r_blue  <= 8'hFF;
      end else begin
        r_red   <= red_in;
        r_green <= green_in;
        r_blue  <= blue_in;
      end
    end
  end

  assign red     = r_red;
  assign green   = r_green;
  assign blue    = r_blue;
  assign hsync_n = r_hs_n;
  assign vsync_n = r_vs_n;
  assign blank_n = r_blank_n;

endmodule
